rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Oldest-first issue select for the reservation station.
//  Keeps an RS_SIZE x RS_SIZE age matrix, stamped on dispatch.
//  Each cycle picks up to ISSUE_W ready entries, at most one per issue lane (one lane per FU class).
//  Honours per-lane FU FIFO stall.
//  Returns the freed-entry mask to the RS, and registers the issue indices toward the FU FIFOs.
// PARAMETERS
//  RS_SIZE  16  number of RS entries
//  ISSUE_W  3   issue lanes (matches RS issue packet width)
//  IDX_W    $clog2(RS_SIZE)  entry index width (derived, do not override)
// PORTS
//  clk          in   1                clock, all state on posedge
//  rst          in   1                reset: synchronous, active-high
//  alloc_mask   in   RS_SIZE          entries written by dispatch this cycle (<= ISSUE_W bits set)
//  lane_req     in   ISSUE_W*RS_SIZE  lane l slice [l*RS_SIZE +: RS_SIZE]: entry valid, both srcs ready, FU class matches lane l
//  fu_stall     in   ISSUE_W          lane l FU FIFO full: no grant on lane l
//  squash       in   1                pipeline flush
//  free_mask    out  RS_SIZE          combinational: entries granted this cycle, freed by RS at next edge
//  issue_valid  out  ISSUE_W          registered: lane l issued the entry in issue_idx[l]
//  issue_idx    out  ISSUE_W*IDX_W    registered: lane l slice [l*IDX_W +: IDX_W]
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - age matrix <= 0; issue_valid <= 0; issue_idx <= 0.
//   - free_mask is 0 while rst=1.
//   - rst mid-operation discards all in-flight grants.
//  Age matrix, older[i][j]=1 means i is older than j. Update on alloc of entry i:
//   - older[i][*] <= 0.
//   - older[j][i] <= 1 for every j != i not in alloc_mask.
//   - Among simultaneous allocs, lower index is older: for alloc j<i, older[j][i]<=1 and older[i][j]<=0.
//   - older[i][i] always 0.
//   - Rows/columns of non-alloc entries are unchanged; stale bits are harmless, only candidates are compared.
//  Eligibility:
//   - cand_l = lane_req slice l & ~alloc_mask & ~(grants of lanes < l).
//   - An entry dispatched this cycle is never selected the same cycle.
//  Select:
//   - Lanes are resolved in order 0..ISSUE_W-1.
//   - Lane l grants the unique i in cand_l with no j in cand_l where older[j][i]=1.
//   - If the matrix is inconsistent (must not happen), take the lowest such index.
//   - No grant if cand_l==0, or fu_stall[l]=1, or squash=1.
//  free_mask = OR of all lane one-hot grants, same cycle (0-cycle latency to RS).
//  Output timing (1-cycle latency):
//   - issue_valid[l] <= grant_l!=0; issue_idx[l] <= encoded grant (0 when none).
//   - Lanes with no grant drive issue_valid=0 next cycle; nothing is held.
//  Squash: no grants, free_mask=0, issue_valid <= 0; age matrix still updates for that cycle's allocs.
//  Simultaneous alloc and grant of the same index is illegal (RS never reuses a granted entry the same cycle); not checked.
//  One entry is granted to at most one lane per cycle.
//  Throughput: up to ISSUE_W grants every cycle, no bubbles.
// TESTING
//  1. rst=1 two cycles, then idle -> issue_valid=0, issue_idx=0, free_mask=0.
//  2. alloc entry 5, then entry 2; next cycle lane_req[0] has bits 2 and 5
//     -> free_mask=16'h0020; following cycle issue_valid=3'b001, issue_idx[0]=5.
//  3. Same alloc alloc_mask=16'h0018 (entries 3,4); next cycle both requested on lane 0 and on lane 1
//     -> lane0 picks 3, lane1 picks 4, free_mask=16'h0018.
//  4. fu_stall=3'b010, lane_req lane1 bit 7 -> no grant, free_mask=0.
//     Drop stall -> entry 7 granted, issue_idx[1]=7 one cycle later.
//  5. Entry 9 in alloc_mask and lane_req the same cycle -> not granted; granted the next cycle.
//  6. squash=1 with three ready entries -> free_mask=0, issue_valid=0 next cycle.
//     rst asserted mid-stream -> all outputs 0 after that edge, age order reset.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue select for the reservation station, one grant per issue lane per cycle.
// Latency: free_mask is same-cycle combinational; issue_valid/issue_idx are registered (1 cycle).
// Backpressure: fu_stall[l] suppresses lane l only; squash or rst suppresses every lane.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   alloc_mask   entries written by dispatch this cycle (stamps the age matrix)
//   lane_req     per-lane ready vectors, lane l in [l*RS_SIZE +: RS_SIZE]
//   fu_stall     per-lane FU FIFO full
//   squash       pipeline flush: no grants this cycle
//   free_mask    one-hot grants OR'd together, freed by the RS at the next edge
//   issue_valid  registered per-lane grant flag
//   issue_idx    registered per-lane granted index, lane l in [l*IDX_W +: IDX_W]
module rs_issue_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int ISSUE_W = 3,
  // Derived from RS_SIZE; not meant to be overridden.
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RS_SIZE-1:0]         alloc_mask,
  input  logic [ISSUE_W*RS_SIZE-1:0] lane_req,
  input  logic [ISSUE_W-1:0]         fu_stall,
  input  logic                       squash,
  output logic [RS_SIZE-1:0]         free_mask,
  output logic [ISSUE_W-1:0]         issue_valid,
  output logic [ISSUE_W*IDX_W-1:0]   issue_idx
);

  // older_q[i][j] = 1 means entry i is older than entry j.
  logic [RS_SIZE-1:0]       older_q [RS_SIZE];
  logic [RS_SIZE-1:0]       older_d [RS_SIZE];
  logic [ISSUE_W-1:0]       issue_valid_q, issue_valid_d;
  logic [ISSUE_W*IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [RS_SIZE-1:0]       taken;

  // Age matrix update. A newly allocated entry is younger than every resident
  // entry; among same-cycle allocations the lower index is the older one.
  // Rows of freed entries are left stale: only live candidates are ever compared.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      older_d[i] = older_q[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (alloc_mask[i]) begin
          older_d[i][j] = alloc_mask[j] && (j > i);
        end else if (alloc_mask[j]) begin
          older_d[i][j] = 1'b1;
        end
      end
    end
  end

  // Lanes resolve in order so an entry granted on a lower lane drops out of
  // the candidate set of every higher lane. A stalled lane grants nothing and
  // therefore leaves its entries available to later lanes.
  always_comb begin
    logic [RS_SIZE-1:0] cand;
    logic [RS_SIZE-1:0] oldest;
    logic [RS_SIZE-1:0] gnt;
    logic [IDX_W-1:0]   idx;
    logic               blocked;
    logic               found;

    taken         = '0;
    issue_valid_d = '0;
    issue_idx_d   = '0;
    cand          = '0;
    oldest        = '0;
    gnt           = '0;
    idx           = '0;
    blocked       = 1'b0;
    found         = 1'b0;

    for (int l = 0; l < ISSUE_W; l++) begin
      cand   = lane_req[l*RS_SIZE +: RS_SIZE] & ~alloc_mask & ~taken;
      oldest = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        blocked = 1'b0;
        for (int j = 0; j < RS_SIZE; j++) begin
          if (cand[j] && older_q[j][i]) begin
            blocked = 1'b1;
          end
        end
        oldest[i] = cand[i] && !blocked;
      end

      // Normally one-hot already; the priority pick only matters if the
      // matrix were ever inconsistent, in which case the lowest index wins.
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (oldest[i] && !found) begin
          gnt[i] = 1'b1;
          idx    = IDX_W'(i);
          found  = 1'b1;
        end
      end

      if (fu_stall[l] || squash || rst) begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
      end

      taken                          = taken | gnt;
      issue_valid_d[l]               = found;
      issue_idx_d[l*IDX_W +: IDX_W]  = idx;
    end
  end

  assign free_mask   = taken;
  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        older_q[i] <= '0;
      end
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        older_q[i] <= older_d[i];
      end
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: each cycle's stimulus pushes its expected
// free_mask and next-cycle issue outputs into a queue; a negedge monitor pops and compares.
// Runs to a summary line by itself; never stalls on the DUT.
module tb_rs_issue_scheduler;
  localparam int RS = 16;
  localparam int IW = 3;
  localparam int IX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [RS-1:0]     alloc_mask;
  logic [IW*RS-1:0]  lane_req;
  logic [IW-1:0]     fu_stall;
  logic              squash;
  logic [RS-1:0]     free_mask;
  logic [IW-1:0]     issue_valid;
  logic [IW*IX-1:0]  issue_idx;

  always #5 clk = ~clk;

  rs_issue_scheduler #(.RS_SIZE(RS), .ISSUE_W(IW), .IDX_W(IX)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_mask  (alloc_mask),
    .lane_req    (lane_req),
    .fu_stall    (fu_stall),
    .squash      (squash),
    .free_mask   (free_mask),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx)
  );

  typedef struct packed {
    logic [RS-1:0]    fr;
    logic [IW-1:0]    v;
    logic [IW*IX-1:0] idx;
  } exp_t;

  exp_t sbq[$];
  exp_t pend;
  bit   have_pend = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: issue outputs seen now belong to the previous cycle's grant.
  always @(negedge clk) begin
    cyc++;
    if (have_pend) begin
      chk("issue_valid", 32'(issue_valid), 32'(pend.v));
      chk("issue_idx", 32'(issue_idx), 32'(pend.idx));
      have_pend = 1'b0;
    end
    if (sbq.size() > 0) begin
      pend = sbq.pop_front();
      chk("free_mask", 32'(free_mask), 32'(pend.fr));
      have_pend = 1'b1;
    end
  end

  task automatic vec(input logic r, input logic [RS-1:0] al,
                     input logic [RS-1:0] l0, input logic [RS-1:0] l1, input logic [RS-1:0] l2,
                     input logic [IW-1:0] st, input logic sq,
                     input logic [RS-1:0] ef, input logic [IW-1:0] ev,
                     input logic [IX-1:0] e0, input logic [IX-1:0] e1, input logic [IX-1:0] e2);
    exp_t e;
    rst        = r;
    alloc_mask = al;
    lane_req   = {l2, l1, l0};
    fu_stall   = st;
    squash     = sq;
    e.fr  = ef;
    e.v   = ev;
    e.idx = {e2, e1, e0};
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    alloc_mask = '0;
    lane_req   = '0;
    fu_stall   = '0;
    squash     = 1'b0;
    @(posedge clk);
    #1;
    //   rst   alloc     lane0     lane1     lane2     stall   sq    free      vld     i0 i1 i2
    // Reset then idle.
    vec(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    // Alloc 5 then 2: 5 is older.
    vec(1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0024, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0020, 3'b001, 5, 0, 0);
    vec(1'b0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0004, 3'b001, 2, 0, 0);
    // Same-cycle alloc of 3,4: lower index older; lane1 takes what lane0 left.
    vec(1'b0, 16'h0018, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0018, 16'h0018, 16'h0000, 3'b000, 1'b0, 16'h0018, 3'b011, 3, 4, 0);
    // Lane1 stall on entry 7, then release.
    vec(1'b0, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 3'b010, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 3'b000, 1'b0, 16'h0080, 3'b010, 0, 7, 0);
    // Entry 9 allocated and requested together: held off one cycle.
    vec(1'b0, 16'h0200, 16'h0200, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0200, 3'b001, 9, 0, 0);
    // Three ready entries under squash, then all three lanes in one cycle.
    vec(1'b0, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0004, 3'b000, 1'b1, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0004, 3'b000, 1'b0, 16'h0007, 3'b111, 0, 1, 2);
    // Lane0 stalled: the oldest of 12/13 (13) falls to lane1; 12 goes next cycle.
    vec(1'b0, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h3000, 16'h3000, 16'h0000, 3'b001, 1'b0, 16'h2000, 3'b010, 0, 13, 0);
    vec(1'b0, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h1000, 3'b001, 12, 0, 0);
    // Allocation during squash still stamps age: 6 before 8, so 6 wins.
    vec(1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b1, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0140, 3'b000, 1'b0, 16'h0040, 3'b100, 0, 0, 6);
    // 11 older than 10, then reset mid-stream clears grants and age order:
    // afterwards the tie resolves to the lower index 10.
    vec(1'b0, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b1, 16'h0000, 16'h0C00, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0C00, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0400, 3'b001, 10, 0, 0);
    // Idle: nothing is held on the issue outputs.
    vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);
    vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sbq.size() + (have_pend ? 1 : 0)), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
